button_event_parser: RTL and testbench

Multi-channel button front end that turns raw asynchronous push-button inputs into clean, single-cycle event pulses for the CPU's memory-mapped I/O and the FPGA top level. Each channel runs through a 2-flop synchronizer, a sampled symmetric debouncer, and an event generator. The generator reports press, release, long-press and auto-repeat events. One shared sample-tick counter serves all channels. The block supersedes the single-edge button chain, adds release, hold and repeat detection, and adds a reset.

---
 rtl/button_event_parser.sv | 139 +++++++++++++
 tb/tb_button_event_parser.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_event_parser.sv
// Multi-channel push-button front end: 2-flop synchronizer, sampled debouncer and
// press/release/long-press/repeat event pulses. release/repeat are SV keywords, hence *_evt.
module button_event_parser #(
    parameter int WIDTH          = 4,
    parameter int SAMPLE_CNT_MAX = 62500,
    parameter int PULSE_CNT_MAX  = 200,
    parameter int HOLD_SAMPLES   = 250,
    parameter int REPEAT_SAMPLES = 50,
    parameter bit REPEAT_EN      = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] press,
    output logic [WIDTH-1:0] release_evt,
    output logic [WIDTH-1:0] long_press,
    output logic [WIDTH-1:0] repeat_evt
);
    localparam int TW = $clog2(SAMPLE_CNT_MAX);
    localparam int SW = $clog2(PULSE_CNT_MAX + 1);
    localparam int HW = $clog2(HOLD_SAMPLES + 1);
    localparam int RW = $clog2(REPEAT_SAMPLES + 1);

    localparam logic [TW-1:0] TICK_LAST = TW'(SAMPLE_CNT_MAX - 1);
    localparam logic [SW-1:0] STAB_LAST = SW'(PULSE_CNT_MAX - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_SAMPLES - 1);
    localparam logic [HW-1:0] HOLD_FULL = HW'(HOLD_SAMPLES);
    localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT_SAMPLES - 1);

    logic [WIDTH-1:0] sync_q1, s;
    logic [TW-1:0]    tick_cnt;
    logic             tick;

    logic [SW-1:0] stab     [WIDTH];
    logic [HW-1:0] hold_cnt [WIDTH];
    logic [RW-1:0] rep_cnt  [WIDTH];

    logic [SW-1:0] stab_d     [WIDTH];
    logic [HW-1:0] hold_cnt_d [WIDTH];
    logic [RW-1:0] rep_cnt_d  [WIDTH];

    logic [WIDTH-1:0] level_d, press_d, release_d, long_d, repeat_d;
    logic [WIDTH-1:0] at_limit, flip;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q1 <= '0;
            s       <= '0;
        end else begin
            sync_q1 <= in;
            s       <= sync_q1;
        end
    end

    // One shared sample strobe for all channels.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            tick_cnt <= '0;
        else if (tick)
            tick_cnt <= '0;
        else
            tick_cnt <= tick_cnt + 1'b1;
    end

    assign tick = (tick_cnt == TICK_LAST);

    always_comb begin
        at_limit = '0;
        for (int i = 0; i < WIDTH; i++)
            at_limit[i] = (stab[i] == STAB_LAST);
    end

    assign flip = {WIDTH{tick}} & (s ^ level) & at_limit;

    always_comb begin
        level_d    = level;
        press_d    = '0;
        release_d  = '0;
        long_d     = '0;
        repeat_d   = '0;
        stab_d     = stab;
        hold_cnt_d = hold_cnt;
        rep_cnt_d  = rep_cnt;
        for (int i = 0; i < WIDTH; i++) begin
            if (flip[i]) begin
                // A flip takes priority over any hold pulse due on the same tick.
                level_d[i]    = s[i];
                press_d[i]    = s[i];
                release_d[i]  = ~s[i];
                stab_d[i]     = '0;
                hold_cnt_d[i] = '0;
                rep_cnt_d[i]  = '0;
            end else if (tick) begin
                stab_d[i] = (s[i] == level[i]) ? '0 : stab[i] + 1'b1;
                if (level[i]) begin
                    if (hold_cnt[i] != HOLD_FULL) begin
                        hold_cnt_d[i] = hold_cnt[i] + 1'b1;
                        if (hold_cnt[i] == HOLD_LAST) begin
                            long_d[i]    = 1'b1;
                            rep_cnt_d[i] = '0;
                        end
                    end else if (rep_cnt[i] == REP_LAST) begin
                        rep_cnt_d[i] = '0;
                        repeat_d[i]  = REPEAT_EN;
                    end else begin
                        rep_cnt_d[i] = rep_cnt[i] + 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level       <= '0;
            press       <= '0;
            release_evt <= '0;
            long_press  <= '0;
            repeat_evt  <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                stab[i]     <= '0;
                hold_cnt[i] <= '0;
                rep_cnt[i]  <= '0;
            end
        end else begin
            level       <= level_d;
            press       <= press_d;
            release_evt <= release_d;
            long_press  <= long_d;
            repeat_evt  <= repeat_d;
            for (int i = 0; i < WIDTH; i++) begin
                stab[i]     <= stab_d[i];
                hold_cnt[i] <= hold_cnt_d[i];
                rep_cnt[i]  <= rep_cnt_d[i];
            end
        end
    end
endmodule

// File: tb/tb_button_event_parser.sv
// Bench for button_event_parser: cycle-level behavioural model plus directed timing checks
// and a randomized phase; a second instance runs with auto-repeat disabled.
module tb_button_event_parser;
    localparam int W    = 2;
    localparam int SCM  = 4;
    localparam int PCM  = 3;
    localparam int HOLD = 5;
    localparam int REP  = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] in  = '0;

    logic [W-1:0] level, press, release_evt, long_press, repeat_evt;
    logic [W-1:0] nr_level, nr_press, nr_release, nr_long, nr_repeat;

    button_event_parser #(
        .WIDTH(W), .SAMPLE_CNT_MAX(SCM), .PULSE_CNT_MAX(PCM),
        .HOLD_SAMPLES(HOLD), .REPEAT_SAMPLES(REP), .REPEAT_EN(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .in(in), .level(level), .press(press),
        .release_evt(release_evt), .long_press(long_press), .repeat_evt(repeat_evt)
    );

    button_event_parser #(
        .WIDTH(W), .SAMPLE_CNT_MAX(SCM), .PULSE_CNT_MAX(PCM),
        .HOLD_SAMPLES(HOLD), .REPEAT_SAMPLES(REP), .REPEAT_EN(1'b0)
    ) dut_nr (
        .clk(clk), .rst(rst), .in(in), .level(nr_level), .press(nr_press),
        .release_evt(nr_release), .long_press(nr_long), .repeat_evt(nr_repeat)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Model state: synced input history, debounced level, run length of opposite
    // samples and number of ticks spent held since the press (-1 when released).
    logic [W-1:0] mq1, mq2, mlvl, e_press, e_rel, e_long, e_rep;
    int run [W];
    int held[W];
    int n;

    int tot_press[W], tot_rel[W], tot_long[W], tot_rep[W];
    int tot_nr_long[W], tot_nr_rep[W], last_press[W];

    function automatic void model_reset();
        mq1 = '0; mq2 = '0; mlvl = '0;
        e_press = '0; e_rel = '0; e_long = '0; e_rep = '0;
        n = 0;
        for (int i = 0; i < W; i++) begin
            run[i]  = 0;
            held[i] = -1;
        end
    endfunction

    function automatic void model_step();
        logic t;
        t = ((n % SCM) == SCM - 1);
        e_press = '0; e_rel = '0; e_long = '0; e_rep = '0;
        for (int i = 0; i < W; i++) begin
            if (t) begin
                logic sv, fl;
                sv = mq2[i];
                fl = 1'b0;
                if (sv != mlvl[i]) begin
                    run[i]++;
                    if (run[i] == PCM) begin
                        fl     = 1'b1;
                        run[i] = 0;
                    end
                end else begin
                    run[i] = 0;
                end
                if (fl) begin
                    mlvl[i] = sv;
                    if (sv) begin
                        e_press[i] = 1'b1;
                        held[i]    = 0;
                    end else begin
                        e_rel[i] = 1'b1;
                        held[i]  = -1;
                    end
                end else if (mlvl[i]) begin
                    held[i]++;
                    if (held[i] == HOLD)
                        e_long[i] = 1'b1;
                    else if (held[i] > HOLD && ((held[i] - HOLD) % REP) == 0)
                        e_rep[i] = 1'b1;
                end
            end
        end
        mq2 = mq1;
        mq1 = in;
        n++;
    endfunction

    // Model step at each rising edge, comparison half a cycle later.
    initial begin
        logic [5*W-1:0] exp_v, act_v, exp_nr, act_nr;
        model_reset();
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst) model_step();
            @(negedge clk);
            if (rst) model_reset();
            exp_v  = {mlvl, e_press, e_rel, e_long, e_rep};
            act_v  = {level, press, release_evt, long_press, repeat_evt};
            exp_nr = {mlvl, e_press, e_rel, e_long, {W{1'b0}}};
            act_nr = {nr_level, nr_press, nr_release, nr_long, nr_repeat};
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL model_cmp cyc=%0d {lvl,prs,rel,long,rep}: got %b, expected %b",
                         cyc, act_v, exp_v);
            end
            checks++;
            if (act_nr !== exp_nr) begin
                errors++;
                $display("FAIL model_cmp_norep cyc=%0d {lvl,prs,rel,long,rep}: got %b, expected %b",
                         cyc, act_nr, exp_nr);
            end
            for (int i = 0; i < W; i++) begin
                if (press[i] === 1'b1) begin
                    tot_press[i]++;
                    last_press[i] = cyc;
                end
                if (release_evt[i] === 1'b1) tot_rel[i]++;
                if (long_press[i] === 1'b1)  tot_long[i]++;
                if (repeat_evt[i] === 1'b1)  tot_rep[i]++;
                if (nr_long[i] === 1'b1)     tot_nr_long[i]++;
                if (nr_repeat[i] === 1'b1)   tot_nr_rep[i]++;
            end
        end
    end

    function automatic logic sig(input int which, input int ch);
        case (which)
            0:       sig = press[ch];
            1:       sig = release_evt[ch];
            2:       sig = long_press[ch];
            3:       sig = repeat_evt[ch];
            default: sig = 1'b0;
        endcase
    endfunction

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic advance(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic step_to(input int target);
        while (cyc < target) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_sig(input string name, input int which, input int ch,
                            input int budget, output int at);
        at = -1;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (sig(which, ch) === 1'b1) begin
                at = cyc;
                break;
            end
        end
        checks++;
        if (at < 0) begin
            errors++;
            $display("FAIL %s: got no pulse, expected one within %0d cycles", name, budget);
        end
    endtask

    initial begin
        int t0, tp, tl, tr, tr2, snap, snap2;
        int sp0, sp1, sl0, sl1;
        int dur[W];

        rst = 1'b1;
        in  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_range("reset_outputs",
                    int'({level, press, release_evt, long_press, repeat_evt}), 0, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Clean press, long press, repeats, release
        advance(5);
        t0 = cyc;
        in[0] = 1'b1;
        wait_sig("press_wait", 0, 0, 30, tp);
        check_range("press_latency", tp - t0, 11, 14);
        check_range("level0_after_press", int'(level[0]), 1, 1);
        check_range("level1_idle", int'(level[1]), 0, 0);
        wait_sig("long_wait", 2, 0, 30, tl);
        check_range("long_after_press", tl - tp, 20, 20);
        wait_sig("rep1_wait", 3, 0, 20, tr);
        check_range("repeat1_after_long", tr - tl, 8, 8);
        wait_sig("rep2_wait", 3, 0, 20, tr2);
        check_range("repeat2_after_long", tr2 - tl, 16, 16);
        advance(1);
        t0 = cyc;
        in[0] = 1'b0;
        wait_sig("release_wait", 1, 0, 30, tr);
        check_range("release_latency", tr - t0, 11, 14);
        snap  = tot_long[0];
        snap2 = tot_rep[0];
        advance(40);
        check_range("no_pulse_after_release", (tot_long[0] - snap) + (tot_rep[0] - snap2), 0, 0);

        // Glitch shorter than the debounce window
        snap  = tot_press[0];
        snap2 = tot_rel[0];
        in[0] = 1'b1;
        advance(6);
        in[0] = 1'b0;
        advance(30);
        check_range("glitch_no_press", tot_press[0] - snap, 0, 0);
        check_range("glitch_no_release", tot_rel[0] - snap2, 0, 0);

        // Release flip on the tick that would carry long_press
        snap = tot_long[0];
        in[0] = 1'b1;
        wait_sig("race_press_wait", 0, 0, 30, tp);
        step_to(tp + 9);
        in[0] = 1'b0;
        wait_sig("race_release_wait", 1, 0, 30, tr);
        check_range("race_release_cycle", tr - tp, 20, 20);
        advance(2);
        check_range("race_no_long", tot_long[0] - snap, 0, 0);
        advance(20);

        // Reset during the repeat phase
        in[0] = 1'b1;
        wait_sig("rst_press_wait", 0, 0, 30, tp);
        wait_sig("rst_long_wait", 2, 0, 30, tl);
        wait_sig("rst_rep_wait", 3, 0, 20, tr);
        advance(1);
        rst = 1'b1;
        @(negedge clk);
        check_range("reset_async_outputs",
                    int'({level, press, release_evt, long_press, repeat_evt}), 0, 0);
        snap = tot_rel[0];
        advance(3);
        rst = 1'b0;
        t0 = cyc;
        wait_sig("rst_repress_wait", 0, 0, 30, tp);
        check_range("repress_latency", tp - t0, 11, 14);
        check_range("no_release_for_lost_press", tot_rel[0] - snap, 0, 0);
        in[0] = 1'b0;
        advance(30);

        // Independent channels with 2-cycle skew
        sp0 = tot_press[0]; sp1 = tot_press[1];
        sl0 = tot_nr_long[0]; sl1 = tot_nr_long[1];
        t0 = cyc;
        in[0] = 1'b1;
        advance(2);
        in[1] = 1'b1;
        advance(20);
        check_range("ch0_press_latency", last_press[0] - t0, 11, 14);
        check_range("ch1_press_latency", last_press[1] - (t0 + 2), 11, 14);
        check_range("ch0_one_press", tot_press[0] - sp0, 1, 1);
        check_range("ch1_one_press", tot_press[1] - sp1, 1, 1);
        advance(24);
        check_range("norep_ch0_long", tot_nr_long[0] - sl0, 1, 1);
        check_range("norep_ch1_long", tot_nr_long[1] - sl1, 1, 1);
        in = '0;
        advance(30);

        // Randomized levels: mix of short glitches and long holds, one reset mid-way
        for (int i = 0; i < W; i++) dur[i] = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < W; i++) begin
                if (dur[i] == 0) begin
                    in[i]  = 1'($urandom_range(0, 1));
                    dur[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 8)
                                                         : $urandom_range(10, 120);
                end
                dur[i]--;
            end
            if (c == 1500) rst = 1'b1;
            if (c == 1503) rst = 1'b0;
            advance(1);
        end
        in = '0;
        advance(40);

        check_range("norep_repeat_never", tot_nr_rep[0] + tot_nr_rep[1], 0, 0);
        check_range("repeat_seen", tot_rep[0] + tot_rep[1], 1, 1000000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
